// File: rtl/phv_action_pairer_if.sv
// Stream and status bundle between the action-stage pairer and its neighbours.
// The master side is whoever feeds PHVs/actions and consumes pairs; the slave is the pairer.
interface phv_action_pairer_if #(
  parameter int PHV_LEN   = 1024,
  parameter int ACT_LEN   = 25,
  parameter int PHV_DEPTH = 4,
  parameter int ACT_DEPTH = 4
);
  localparam int ACT_W  = ACT_LEN * 25;
  localparam int PHV_LW = $clog2(PHV_DEPTH) + 1;
  localparam int ACT_LW = $clog2(ACT_DEPTH) + 1;

  logic [PHV_LEN-1:0] phv_in;
  logic               phv_in_valid;
  logic               phv_in_ready;
  logic [ACT_W-1:0]   action_in;
  logic               action_in_valid;
  logic               action_in_ready;
  logic [PHV_LEN-1:0] xbar_phv;
  logic [ACT_W-1:0]   xbar_action;
  logic               xbar_valid;
  logic               xbar_ready;
  logic [31:0]        pair_cnt;
  logic               pair_cnt_load;
  logic [31:0]        pair_cnt_load_val;
  logic [PHV_LW-1:0]  phv_level;
  logic [ACT_LW-1:0]  act_level;
  logic               err_timeout;

  modport master (
    output phv_in, phv_in_valid, action_in, action_in_valid, xbar_ready,
           pair_cnt_load, pair_cnt_load_val,
    input  phv_in_ready, action_in_ready, xbar_phv, xbar_action, xbar_valid,
           pair_cnt, phv_level, act_level, err_timeout
  );

  modport slave (
    input  phv_in, phv_in_valid, action_in, action_in_valid, xbar_ready,
           pair_cnt_load, pair_cnt_load_val,
    output phv_in_ready, action_in_ready, xbar_phv, xbar_action, xbar_valid,
           pair_cnt, phv_level, act_level, err_timeout
  );
endinterface

// File: rtl/phv_action_pairer.sv
// Buffers PHVs and action words in separate in-order FIFOs and issues them to the
// crossbar as strict Nth-with-Nth pairs, one per cycle, with pair count and timeout status.
module phv_action_pairer #(
  parameter int PHV_LEN   = 1024,
  parameter int ACT_LEN   = 25,
  parameter int PHV_DEPTH = 4,
  parameter int ACT_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input logic              clk,
  input logic              rst_n,
  phv_action_pairer_if.slave bus
);
  localparam int ACT_W = ACT_LEN * 25;
  localparam int PAW   = $clog2(PHV_DEPTH);
  localparam int AAW   = $clog2(ACT_DEPTH);
  localparam int PLW   = PAW + 1;
  localparam int ALW   = AAW + 1;
  localparam int CW    = $clog2(TIMEOUT + 1);

  logic [PHV_LEN-1:0] r_phvMem [PHV_DEPTH];
  logic [ACT_W-1:0]   r_actMem [ACT_DEPTH];
  logic [PLW-1:0]     r_phvWr, r_phvRd, r_phvLevel;
  logic [ALW-1:0]     r_actWr, r_actRd, r_actLevel;
  logic               r_rdyEn;
  logic               r_xbarValid;
  logic [PHV_LEN-1:0] r_xbarPhv;
  logic [ACT_W-1:0]   r_xbarAct;
  logic [31:0]        r_pairCnt;
  logic [CW-1:0]      r_toCnt;
  logic               r_err;

  logic w_phvEmpty, w_phvFull, w_phvReady, w_phvPush;
  logic w_actEmpty, w_actFull, w_actReady, w_actPush;
  logic w_adv, w_oneSide;

  // Readies stay low through reset and open on the first edge after release.
  assign w_phvEmpty = (r_phvWr == r_phvRd);
  assign w_phvFull  = (r_phvWr[PAW] != r_phvRd[PAW]) && (r_phvWr[PAW-1:0] == r_phvRd[PAW-1:0]);
  assign w_phvReady = r_rdyEn & ~w_phvFull;
  assign w_phvPush  = bus.phv_in_valid & w_phvReady;
  assign w_actEmpty = (r_actWr == r_actRd);
  assign w_actFull  = (r_actWr[AAW] != r_actRd[AAW]) && (r_actWr[AAW-1:0] == r_actRd[AAW-1:0]);
  assign w_actReady = r_rdyEn & ~w_actFull;
  assign w_actPush  = bus.action_in_valid & w_actReady;
  assign w_adv      = (~r_xbarValid | bus.xbar_ready) & ~w_phvEmpty & ~w_actEmpty;
  assign w_oneSide  = w_phvEmpty ^ w_actEmpty;

  always_ff @(posedge clk) begin
    if (w_phvPush) r_phvMem[r_phvWr[PAW-1:0]] <= bus.phv_in;
    if (w_actPush) r_actMem[r_actWr[AAW-1:0]] <= bus.action_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdyEn    <= 1'b0;
      r_phvWr    <= '0;
      r_phvRd    <= '0;
      r_phvLevel <= '0;
      r_actWr    <= '0;
      r_actRd    <= '0;
      r_actLevel <= '0;
    end else begin
      r_rdyEn <= 1'b1;
      if (w_phvPush) r_phvWr <= r_phvWr + PLW'(1);
      if (w_actPush) r_actWr <= r_actWr + ALW'(1);
      if (w_adv) begin
        r_phvRd <= r_phvRd + PLW'(1);
        r_actRd <= r_actRd + ALW'(1);
      end
      case ({w_phvPush, w_adv})
        2'b10:   r_phvLevel <= r_phvLevel + PLW'(1);
        2'b01:   r_phvLevel <= r_phvLevel - PLW'(1);
        default: r_phvLevel <= r_phvLevel;
      endcase
      case ({w_actPush, w_adv})
        2'b10:   r_actLevel <= r_actLevel + ALW'(1);
        2'b01:   r_actLevel <= r_actLevel - ALW'(1);
        default: r_actLevel <= r_actLevel;
      endcase
    end
  end

  // Output register holds its pair while the crossbar stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xbarValid <= 1'b0;
      r_xbarPhv   <= '0;
      r_xbarAct   <= '0;
      r_pairCnt   <= '0;
    end else begin
      if (w_adv) begin
        r_xbarValid <= 1'b1;
        r_xbarPhv   <= r_phvMem[r_phvRd[PAW-1:0]];
        r_xbarAct   <= r_actMem[r_actRd[AAW-1:0]];
      end else if (bus.xbar_ready) begin
        r_xbarValid <= 1'b0;
      end
      if (bus.pair_cnt_load) r_pairCnt <= bus.pair_cnt_load_val;
      else if (w_adv)        r_pairCnt <= r_pairCnt + 32'd1;
    end
  end

  // The error flag rises on the same edge the saturating counter reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toCnt <= '0;
      r_err   <= 1'b0;
    end else if (!w_oneSide) begin
      r_toCnt <= '0;
    end else begin
      if (r_toCnt != CW'(TIMEOUT)) r_toCnt <= r_toCnt + CW'(1);
      if (r_toCnt >= CW'(TIMEOUT - 1)) r_err <= 1'b1;
    end
  end

  assign bus.phv_in_ready    = w_phvReady;
  assign bus.action_in_ready = w_actReady;
  assign bus.xbar_phv        = r_xbarPhv;
  assign bus.xbar_action     = r_xbarAct;
  assign bus.xbar_valid      = r_xbarValid;
  assign bus.pair_cnt        = r_pairCnt;
  assign bus.phv_level       = r_phvLevel;
  assign bus.act_level       = r_actLevel;
  assign bus.err_timeout     = r_err;
endmodule

// File: tb/tb_phv_action_pairer.sv
// Directed bench for phv_action_pairer: reset, in-order pairing, backpressure,
// full-FIFO refusal, pairing timeout and pair counter wrap.
module tb_phv_action_pairer;
  localparam int PHV_LEN = 1024;
  localparam int ACT_LEN = 25;
  localparam int ACT_W   = ACT_LEN * 25;
  localparam int DEPTH   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   testCount = 0;
  int   failCount = 0;

  phv_action_pairer_if #(.PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN),
                         .PHV_DEPTH(DEPTH), .ACT_DEPTH(DEPTH)) bus();

  phv_action_pairer #(.PHV_LEN(PHV_LEN), .ACT_LEN(ACT_LEN), .PHV_DEPTH(DEPTH),
                      .ACT_DEPTH(DEPTH), .TIMEOUT(255)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [PHV_LEN-1:0] phvVal(input int v);
    return PHV_LEN'(v);
  endfunction

  function automatic logic [ACT_W-1:0] actVal(input int v);
    return ACT_W'(v);
  endfunction

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  // Drive one cycle of inputs, then step to just after the next rising edge.
  task automatic applyStimulus(input logic pv, input logic [PHV_LEN-1:0] phv,
                               input logic av, input logic [ACT_W-1:0] act, input logic xr);
    bus.phv_in_valid    = pv;
    bus.phv_in          = phv;
    bus.action_in_valid = av;
    bus.action_in       = act;
    bus.xbar_ready      = xr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic xr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, xr);
  endtask

  initial begin
    bus.phv_in_valid      = 1'b0;
    bus.phv_in            = '0;
    bus.action_in_valid   = 1'b0;
    bus.action_in         = '0;
    bus.xbar_ready        = 1'b1;
    bus.pair_cnt_load     = 1'b0;
    bus.pair_cnt_load_val = '0;

    // Power-on reset
    #1;
    checkOutput("por_phv_ready", bus.phv_in_ready, 0);
    checkOutput("por_act_ready", bus.action_in_ready, 0);
    checkOutput("por_valid", bus.xbar_valid, 0);
    checkOutput("por_cnt", bus.pair_cnt, 0);
    checkOutput("por_err", bus.err_timeout, 0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rel_phv_ready", bus.phv_in_ready, 1);
    checkOutput("rel_act_ready", bus.action_in_ready, 1);
    checkOutput("rel_phv_level", bus.phv_level, 0);
    checkOutput("rel_act_level", bus.act_level, 0);

    // In-order pairing: PHVs first, actions five cycles later
    applyStimulus(1'b1, phvVal('hA), 1'b0, '0, 1'b1);
    applyStimulus(1'b1, phvVal('hB), 1'b0, '0, 1'b1);
    applyStimulus(1'b1, phvVal('hC), 1'b0, '0, 1'b1);
    checkOutput("ord_phv_level", bus.phv_level, 3);
    idle(2, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, actVal('h1a), 1'b1);
    checkOutput("ord_valid_t6", bus.xbar_valid, 0);
    applyStimulus(1'b0, '0, 1'b1, actVal('h1b), 1'b1);
    checkOutput("ord_valid_t7", bus.xbar_valid, 1);
    checkOutput("ord_phv_A", bus.xbar_phv, 'hA);
    checkOutput("ord_act_a", bus.xbar_action, 'h1a);
    checkOutput("ord_cnt1", bus.pair_cnt, 1);
    applyStimulus(1'b0, '0, 1'b1, actVal('h1c), 1'b1);
    checkOutput("ord_phv_B", bus.xbar_phv, 'hB);
    checkOutput("ord_act_b", bus.xbar_action, 'h1b);
    idle(1, 1'b1);
    checkOutput("ord_phv_C", bus.xbar_phv, 'hC);
    checkOutput("ord_act_c", bus.xbar_action, 'h1c);
    checkOutput("ord_cnt3", bus.pair_cnt, 3);
    idle(1, 1'b1);
    checkOutput("ord_valid_end", bus.xbar_valid, 0);

    // Backpressure: crossbar stalls six cycles while five pairs queue up
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, phvVal('h100 + k), 1'b1, actVal('h200 + k), 1'b0);
      if (k == 1) checkOutput("bp_head_phv", bus.xbar_phv, 'h100);
      if (k == 4) begin
        checkOutput("bp_phv_level", bus.phv_level, 4);
        checkOutput("bp_act_level", bus.act_level, 4);
        checkOutput("bp_phv_ready", bus.phv_in_ready, 0);
        checkOutput("bp_act_ready", bus.action_in_ready, 0);
      end
    end
    checkOutput("bp_hold_valid", bus.xbar_valid, 1);
    checkOutput("bp_hold_phv", bus.xbar_phv, 'h100);
    checkOutput("bp_hold_act", bus.xbar_action, 'h200);
    checkOutput("bp_level_held", bus.phv_level, 4);
    for (int j = 1; j < 5; j++) begin
      idle(1, 1'b1);
      checkOutput($sformatf("bp_drain_phv%0d", j), bus.xbar_phv, 'h100 + j);
      checkOutput($sformatf("bp_drain_act%0d", j), bus.xbar_action, 'h200 + j);
    end
    idle(1, 1'b1);
    checkOutput("bp_valid_end", bus.xbar_valid, 0);
    checkOutput("bp_phv_empty", bus.phv_level, 0);
    checkOutput("bp_act_empty", bus.act_level, 0);
    checkOutput("bp_cnt", bus.pair_cnt, 8);

    // Full PHV FIFO with a pop and a push offered in the same cycle
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, phvVal('h300 + k), 1'b0, '0, 1'b1);
    checkOutput("full_level", bus.phv_level, 4);
    applyStimulus(1'b1, phvVal('h304), 1'b1, actVal('h400), 1'b1);
    checkOutput("full_still4", bus.phv_level, 4);
    checkOutput("full_ready0", bus.phv_in_ready, 0);
    applyStimulus(1'b1, phvVal('h304), 1'b0, '0, 1'b1);
    checkOutput("full_pop_level", bus.phv_level, 3);
    checkOutput("full_ready1", bus.phv_in_ready, 1);
    checkOutput("full_pair_phv", bus.xbar_phv, 'h300);
    applyStimulus(1'b1, phvVal('h304), 1'b0, '0, 1'b1);
    checkOutput("full_accept", bus.phv_level, 4);
    for (int k = 1; k < 5; k++) applyStimulus(1'b0, '0, 1'b1, actVal('h400 + k), 1'b1);
    idle(1, 1'b1);
    checkOutput("full_last_phv", bus.xbar_phv, 'h304);
    checkOutput("full_last_act", bus.xbar_action, 'h404);
    checkOutput("full_cnt", bus.pair_cnt, 13);
    idle(1, 1'b1);
    checkOutput("full_drained", bus.phv_level, 0);

    // Timeout: one PHV waits with no action
    applyStimulus(1'b1, phvVal('h500), 1'b0, '0, 1'b1);
    idle(254, 1'b1);
    checkOutput("to_err_254", bus.err_timeout, 0);
    idle(1, 1'b1);
    checkOutput("to_err_255", bus.err_timeout, 1);
    idle(10, 1'b1);
    checkOutput("to_err_sticky", bus.err_timeout, 1);
    checkOutput("to_phv_level", bus.phv_level, 1);
    applyStimulus(1'b0, '0, 1'b1, actVal('h600), 1'b1);
    idle(1, 1'b1);
    checkOutput("to_pair_valid", bus.xbar_valid, 1);
    checkOutput("to_pair_phv", bus.xbar_phv, 'h500);
    checkOutput("to_pair_act", bus.xbar_action, 'h600);
    checkOutput("to_cnt", bus.pair_cnt, 14);
    checkOutput("to_err_after", bus.err_timeout, 1);

    // Pair counter wrap
    bus.pair_cnt_load     = 1'b1;
    bus.pair_cnt_load_val = 32'hFFFF_FFFE;
    idle(1, 1'b1);
    bus.pair_cnt_load     = 1'b0;
    checkOutput("wrap_load", bus.pair_cnt, 32'hFFFF_FFFE);
    applyStimulus(1'b1, phvVal('h700), 1'b1, actVal('h800), 1'b1);
    applyStimulus(1'b1, phvVal('h701), 1'b1, actVal('h801), 1'b1);
    checkOutput("wrap_ffffffff", bus.pair_cnt, 32'hFFFF_FFFF);
    applyStimulus(1'b1, phvVal('h702), 1'b1, actVal('h802), 1'b1);
    checkOutput("wrap_zero", bus.pair_cnt, 0);
    idle(1, 1'b1);
    checkOutput("wrap_one", bus.pair_cnt, 1);

    // Asynchronous reset mid-stream with three PHVs buffered and a held pair
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, phvVal('h900 + k), 1'b0, '0, 1'b0);
    checkOutput("rst_pre_level", bus.phv_level, 3);
    checkOutput("rst_pre_valid", bus.xbar_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_level", bus.phv_level, 0);
    checkOutput("rst_valid", bus.xbar_valid, 0);
    checkOutput("rst_phv", bus.xbar_phv, 0);
    checkOutput("rst_act", bus.xbar_action, 0);
    checkOutput("rst_cnt", bus.pair_cnt, 0);
    checkOutput("rst_err", bus.err_timeout, 0);
    checkOutput("rst_phv_ready", bus.phv_in_ready, 0);
    bus.phv_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_rel_phv_ready", bus.phv_in_ready, 1);
    checkOutput("rst_rel_act_ready", bus.action_in_ready, 1);
    checkOutput("rst_rel_phv_level", bus.phv_level, 0);
    checkOutput("rst_rel_act_level", bus.act_level, 0);
    checkOutput("rst_rel_valid", bus.xbar_valid, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
